// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  // RV32M funct3 encoding.
  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } muldiv_state_t;

  // MUL is treated as signed; its low half is the same either way.
  function automatic logic is_signed_a(muldiv_op_t op);
    return op inside {OpMul, OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic is_signed_b(muldiv_op_t op);
    return op inside {OpMul, OpMulh, OpDiv, OpRem};
  endfunction

  function automatic logic is_div(muldiv_op_t op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: MSB-first shift-add for multiply, or one
// restoring trial-subtract for divide. Divide layout: acc = {rem, quotient}.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            div,
  input  logic [2*XLEN:0] acc_in,
  input  logic [XLEN-1:0] operand,   // multiplicand or divisor magnitude
  input  logic            bit_in,    // current multiplier or dividend bit
  output logic [2*XLEN:0] acc_out
);

  logic [2*XLEN:0] prod;
  logic [XLEN+1:0] rem_shift;
  logic [XLEN:0]   diff;
  logic            ge;

  // Compute both candidate updates and select by operation class.
  always_comb begin
    prod      = {acc_in[2*XLEN-1:0], 1'b0}
              + {{(XLEN+1){1'b0}}, (bit_in ? operand : {XLEN{1'b0}})};
    rem_shift = {acc_in[2*XLEN:XLEN], bit_in};
    ge        = rem_shift >= {2'b00, operand};
    diff      = rem_shift[XLEN:0] - {1'b0, operand};
    if (div) begin
      if (ge) acc_out = {diff, acc_in[XLEN-2:0], 1'b1};
      else    acc_out = {rem_shift[XLEN:0], acc_in[XLEN-2:0], 1'b0};
    end else begin
      acc_out = prod;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle, stalls the
// pipeline while busy and pulses done for one cycle with a registered result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t   state_q, state_d;
  muldiv_op_t      op_in, op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*XLEN:0] acc_q, acc_d, step_acc;
  logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic            neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

  logic            accept, special, sa, sb, div_q, step_bit;
  logic [XLEN-1:0] mag_a, mag_b, special_val, step_opnd, final_val;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quot, rem;

  assign op_in  = muldiv_op_t'(op);
  assign accept = (state_q == StIdle) & start & ~kill;
  assign div_q  = is_div(op_q);

  // Operand magnitudes and the cases that finish without iterating.
  always_comb begin
    sa          = is_signed_a(op_in) & a[XLEN-1];
    sb          = is_signed_b(op_in) & b[XLEN-1];
    mag_a       = sa ? -a : a;
    mag_b       = sb ? -b : b;
    special     = 1'b0;
    special_val = '0;
    if (is_div(op_in)) begin
      if (b == '0) begin
        special     = 1'b1;
        special_val = (op_in inside {OpDiv, OpDivu}) ? {XLEN{1'b1}} : a;
      end else if (a == MinNeg && b == {XLEN{1'b1}} && op_in inside {OpDiv, OpRem}) begin
        special     = 1'b1;
        special_val = (op_in == OpDiv) ? a : '0;
      end
    end
  end

  assign step_opnd = div_q ? opb_q : opa_q;
  assign step_bit  = div_q ? opa_q[cnt_q] : opb_q[cnt_q];

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .div     (div_q),
    .acc_in  (acc_q),
    .operand (step_opnd),
    .bit_in  (step_bit),
    .acc_out (step_acc)
  );

  // Sign correction and half/quotient/remainder selection on the last step.
  always_comb begin
    prod      = step_acc[2*XLEN-1:0];
    prod_fix  = neg_res_q ? -prod : prod;
    quot      = step_acc[XLEN-1:0];
    rem       = step_acc[2*XLEN-1:XLEN];
    final_val = '0;
    unique case (op_q)
      OpMul:                      final_val = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu:  final_val = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:              final_val = neg_res_q ? -quot : quot;
      OpRem, OpRemu:              final_val = neg_rem_q ? -rem : rem;
      default:                    final_val = '0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state; kill wins over everything but reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = special ? StDone : StCalc;
      StCalc: begin
        if (kill)               state_d = StIdle;
        else if (cnt_q == '0)   state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs; stall is suppressed while reset is asserted.
  always_comb begin
    stall_req = reset & (accept | (state_q == StCalc));
    done      = (state_q == StDone);
  end

  // Datapath next state: latch on accept, iterate in CALC unless killed.
  always_comb begin
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    if (accept) begin
      op_d      = op_in;
      opa_d     = mag_a;
      opb_d     = mag_b;
      neg_res_d = sa ^ sb;
      neg_rem_d = sa;
      acc_d     = '0;
      cnt_d     = CntW'(XLEN - 1);
      if (special) result_d = special_val;
    end else if (state_q == StCalc && !kill) begin
      acc_d = step_acc;
      if (cnt_q == '0) result_d = final_val;
      else             cnt_d    = cnt_q - CntW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= OpMul;
      opa_q     <= '0;
      opb_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      op_q      <= op_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign result = result_q;

endmodule
